lcd_bus_rx: RTL and testbench
=============================

LCD_BUS_RX -- requirements
Module: lcd_bus_rx

Interface
REQ-001 clk  in  1  single system clock; all logic on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 control  in  3  LCD bus controls [E, RS(D/C'), R/W'], as driven by the team's LCD writer.
REQ-004 dataout  in  4  LCD bus data nibble; DB7..DB4 in 4-bit mode.
REQ-005 RADD  in  5  host read address into the 32-byte shadow display RAM.
REQ-006 RDATA  out  8  shadow RAM byte at RADD; registered, 1-cycle latency.
REQ-007 byte_valid  out  1  one-cycle pulse when a complete bus byte is decoded.
REQ-008 byte_rs  out  1  RS of the decoded byte (1 = data, 0 = command); valid with byte_valid.
REQ-009 byte_val  out  8  decoded byte; valid with byte_valid.
REQ-010 disp_on  out  1  display-on bit from the last display-control command.
REQ-011 mode4  out  1  high once the 4-bit interface is established.
REQ-012 err  out  1  sticky protocol-error flag; cleared only by rst.

Function
REQ-013 E falling edge SHALL be detected as E registered high and current E low; RS, R/W' and the data nibble SHALL be captured from the registered copy (value present while E was high).
REQ-014 E pulses high for fewer than 2 consecutive clk cycles SHALL be ignored and SHALL set err.
REQ-015 Strobes with R/W'=1 SHALL be ignored (no reads supported) and SHALL set err.
REQ-016 FSM states: INIT8, HI, LO, CLR; after reset the FSM SHALL be in CLR, then go to INIT8.
REQ-017 INIT8: each strobe is a single-nibble command; nibble 0x3 stays in INIT8; nibble 0x2 SHALL set mode4 and move to HI; any other nibble SHALL set err and stay in INIT8.
REQ-018 HI: strobe latches the upper nibble and moves to LO; LO: strobe forms {hi, lo} and returns to HI.
REQ-019 byte_valid SHALL pulse in the cycle after the LO-state falling edge is detected.
REQ-020 Command 0x01 SHALL move to CLR: 32 consecutive cycles writing 0x20 to addresses 0..31, cursor set to 0, then return to HI.
REQ-021 Any strobe during CLR SHALL be dropped and SHALL set err.
REQ-022 Command 0x80|a SHALL set cursor = {a[6], a[3:0]}, mapping line 1 (0x80) to 0..15 and line 2 (0xC0) to 16..31.
REQ-023 Command 0000_1DCB SHALL load disp_on = D; 0000_01I S SHALL load the increment flag = I; 001x_xxxx (function set) SHALL be accepted with no effect; all other commands SHALL be ignored.
REQ-024 Data byte SHALL be written to RAM[cursor]; cursor SHALL then be incremented (I=1) or decremented (I=0), modulo 32 (31 -> 0, 0 -> 31).
REQ-025 A RAM write and a host read of the same address in the same cycle SHALL return the old data (read-before-write).

Reset
REQ-026 On rst: FSM to CLR, cursor 0, increment flag 1, disp_on 0, mode4 0, err 0, byte_valid 0, byte_rs 0, byte_val 0x00, RDATA 0x00.
REQ-027 The RAM SHALL NOT be reset directly; the post-reset CLR sweep fills it with 0x20.
REQ-028 rst asserted mid-byte or mid-sweep SHALL discard the partial byte and restart the sweep.

Configuration
REQ-029 LCD_BUS_RX_BUSY_EN defined: after each decoded byte, a busy counter SHALL run for BUSY_CYC cycles (parameter, default 2000; 82000 after 0x01).
REQ-030 With LCD_BUS_RX_BUSY_EN, any strobe while busy SHALL be dropped and SHALL set err.
REQ-031 LCD_BUS_RX_BUSY_EN undefined: no busy counter, no timing checks, BUSY_CYC unused.

Structure
REQ-032 Shared package lcd_pkg SHALL hold the FSM state encoding, command codes (0x01, 0x80, 0xC0, 0x28, 0x0C, 0x06), the blank char 0x20, and the control bit indices E=2, RS=1, RW=0.
REQ-033 One sub-module, lcd_shadow_ram: 32x8 RAM with one synchronous write port and one registered read port.

Verification
REQ-034 Init sequence: nibbles 3,3,3,2, then bytes 0x28, 0x0C, 0x06, 0x01 -> mode4=1, disp_on=1, RAM all 0x20 after 32 cycles, err=0.
REQ-035 Cmd 0x80, then data "Hi" -> RAM[0]=0x48, RAM[1]=0x69, two byte_valid pulses with byte_rs=1.
REQ-036 Cmd 0xC0, then 17 data bytes -> bytes 1..16 in RAM[16..31], 17th byte in RAM[0] (wrap).
REQ-037 1-cycle E glitch, then a strobe with R/W'=1 -> err=1, RAM and cursor unchanged.
REQ-038 rst pulse between high and low nibble -> no byte_valid; CLR sweep reruns; RAM all 0x20.
REQ-039 With LCD_BUS_RX_BUSY_EN: two bytes spaced 100 cycles apart -> second byte dropped, err=1.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared encodings for the LCD bus receiver: FSM states, HD44780 command codes,
// blank character and the bit positions inside the 3-bit control bus.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_INIT8 = 2'd0,
        ST_HI    = 2'd1,
        ST_LO    = 2'd2,
        ST_CLR   = 2'd3
    } lcd_state_t;

    localparam int RAM_DEPTH = 32;
    localparam int ADDR_W    = 5;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_LINE1     = 8'h80;
    localparam logic [7:0] CMD_LINE2     = 8'hC0;
    localparam logic [7:0] CMD_FUNC_4BIT = 8'h28;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_ENTRY_INC = 8'h06;

    localparam logic [7:0] BLANK_CHAR = 8'h20;

    localparam logic [3:0] NIB_WAKE = 4'h3;
    localparam logic [3:0] NIB_4BIT = 4'h2;

    localparam int CTL_E  = 2;
    localparam int CTL_RS = 1;
    localparam int CTL_RW = 0;

    // Line 1 (0x80..0x8F) maps to 0..15, line 2 (0xC0..0xCF) to 16..31.
    function automatic logic [ADDR_W-1:0] ddram_to_cursor(input logic [7:0] cmd);
        return {|(cmd & CMD_LINE2 & ~CMD_LINE1), cmd[3:0]};
    endfunction

endpackage

// File: rtl/lcd_shadow_ram.sv
// 32x8 shadow display RAM: one synchronous write port, one registered read port
// that returns the pre-write contents when both hit the same address.
module lcd_shadow_ram
    import lcd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/lcd_bus_rx.sv
// Snoops the 4-bit HD44780 writer bus, decodes bytes and mirrors the display
// into a shadow RAM. Define LCD_BUS_RX_BUSY_EN to enforce controller busy time.
module lcd_bus_rx
    import lcd_pkg::*;
#(
    parameter int BUSY_CYC     = 2000,
    parameter int BUSY_CLR_CYC = 82000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  control,
    input  logic [3:0]  dataout,
    input  logic [4:0]  RADD,
    output logic [7:0]  RDATA,
    output logic        byte_valid,
    output logic        byte_rs,
    output logic [7:0]  byte_val,
    output logic        disp_on,
    output logic        mode4,
    output logic        err
);

    lcd_state_t        state;
    logic [2:0]        ctl_p0;
    logic [3:0]        dat_p0;
    logic [1:0]        e_run_p0;
    logic [3:0]        hi_nib;
    logic [7:0]        byte_cur;
    logic [ADDR_W-1:0] cursor;
    logic [ADDR_W-1:0] clr_addr;
    logic              inc;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              e_fall;
    logic              e_short;
    logic              e_read;
    logic              strobe_raw;
    logic              strobe_drop;
    logic              strobe;

    // Stage p0: registered bus copy and length of the current E-high run
    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_p0   <= '0;
            e_run_p0 <= '0;
        end else begin
            ctl_p0 <= control;
            if (control[CTL_E]) begin
                e_run_p0 <= (e_run_p0 == 2'd2) ? 2'd2 : e_run_p0 + 2'd1;
            end else begin
                e_run_p0 <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        dat_p0 <= dataout;
    end

    assign e_fall      = ctl_p0[CTL_E] & ~control[CTL_E];
    assign e_short     = e_fall & (e_run_p0 < 2'd2);
    assign e_read      = e_fall & ~e_short & ctl_p0[CTL_RW];
    assign strobe_raw  = e_fall & ~e_short & ~ctl_p0[CTL_RW];
    assign strobe_drop = strobe_raw & ((state == ST_CLR) | busy);
    assign strobe      = strobe_raw & ~strobe_drop;
    assign byte_cur    = {hi_nib, dat_p0};

`ifdef LCD_BUS_RX_BUSY_EN
    localparam int BUSY_MAX = (BUSY_CLR_CYC > BUSY_CYC) ? BUSY_CLR_CYC : BUSY_CYC;
    localparam int BUSY_W   = $clog2(BUSY_MAX + 1);

    logic [BUSY_W-1:0] busy_cnt;

    // The clear command keeps the real controller busy far longer than other bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt <= '0;
        end else if ((state == ST_LO) && strobe) begin
            busy_cnt <= (!ctl_p0[CTL_RS] && (byte_cur == CMD_CLEAR)) ?
                        BUSY_W'(BUSY_CLR_CYC) : BUSY_W'(BUSY_CYC);
        end else if (busy_cnt != '0) begin
            busy_cnt <= busy_cnt - 1'b1;
        end
    end

    assign busy = (busy_cnt != '0);
`else
    assign busy = 1'b0;
`endif

    // Stage p1: decode FSM, registered outputs and RAM write request
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_CLR;
            clr_addr   <= '0;
            cursor     <= '0;
            inc        <= 1'b1;
            disp_on    <= 1'b0;
            mode4      <= 1'b0;
            err        <= 1'b0;
            byte_valid <= 1'b0;
            byte_rs    <= 1'b0;
            byte_val   <= '0;
            wr_en      <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            wr_en      <= 1'b0;
            if (e_short | e_read | strobe_drop) begin
                err <= 1'b1;
            end
            case (state)
                ST_CLR: begin
                    wr_en    <= 1'b1;
                    wr_addr  <= clr_addr;
                    wr_data  <= BLANK_CHAR;
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == ADDR_W'(RAM_DEPTH - 1)) begin
                        cursor <= '0;
                        state  <= mode4 ? ST_HI : ST_INIT8;
                    end
                end
                ST_INIT8: begin
                    if (strobe) begin
                        if (dat_p0 == NIB_4BIT) begin
                            mode4 <= 1'b1;
                            state <= ST_HI;
                        end else if (dat_p0 != NIB_WAKE) begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_HI: begin
                    if (strobe) begin
                        hi_nib <= dat_p0;
                        state  <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (strobe) begin
                        byte_valid <= 1'b1;
                        byte_rs    <= ctl_p0[CTL_RS];
                        byte_val   <= byte_cur;
                        state      <= ST_HI;
                        if (ctl_p0[CTL_RS]) begin
                            wr_en   <= 1'b1;
                            wr_addr <= cursor;
                            wr_data <= byte_cur;
                            cursor  <= inc ? cursor + 1'b1 : cursor - 1'b1;
                        end else if (byte_cur == CMD_CLEAR) begin
                            clr_addr <= '0;
                            state    <= ST_CLR;
                        end else if (byte_cur[7]) begin
                            cursor <= ddram_to_cursor(byte_cur);
                        end else if ((byte_cur & 8'hF8) == (CMD_DISP_ON & 8'hF8)) begin
                            disp_on <= byte_cur[2];
                        end else if ((byte_cur & 8'hFC) == (CMD_ENTRY_INC & 8'hFC)) begin
                            inc <= byte_cur[1];
                        end else if ((byte_cur & 8'hE0) == (CMD_FUNC_4BIT & 8'hE0)) begin
                            // Function set is legal traffic but changes nothing here.
                        end
                    end
                end
                default: state <= ST_CLR;
            endcase
        end
    end

    lcd_shadow_ram u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (RADD),
        .rdata (RDATA)
    );

endmodule

// File: tb/tb_lcd_bus_rx.sv
// Directed bench for lcd_bus_rx: init sequence, vector table of bytes with RAM
// readback, then hand-written glitch/read-strobe, busy and mid-byte reset cases.
module tb_lcd_bus_rx;

`ifdef LCD_BUS_RX_BUSY_EN
    localparam int IDLE_BYTE  = 170;
    localparam int CLR_WAIT   = 200;
    localparam logic [4:0] GA = 5'd2;
    localparam logic [7:0] GA_PREV = 8'h31;
`else
    localparam int IDLE_BYTE  = 3;
    localparam int CLR_WAIT   = 40;
    localparam logic [4:0] GA = 5'd1;
    localparam logic [7:0] GA_PREV = 8'h77;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] control;
    logic [3:0] dataout;
    logic [4:0] RADD;
    logic [7:0] RDATA;
    logic       byte_valid;
    logic       byte_rs;
    logic [7:0] byte_val;
    logic       disp_on;
    logic       mode4;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;
    logic       last_rs = 1'b0;
    logic [7:0] last_val = 8'h00;

    typedef struct {
        logic       rs;
        logic [7:0] b;
        logic       chk;
        logic [4:0] addr;
        logic [7:0] exp;
        logic       disp;
    } vec_t;

    vec_t vecs[$];

    lcd_bus_rx #(.BUSY_CYC(150), .BUSY_CLR_CYC(160)) dut (
        .clk        (clk),
        .rst        (rst),
        .control    (control),
        .dataout    (dataout),
        .RADD       (RADD),
        .RDATA      (RDATA),
        .byte_valid (byte_valid),
        .byte_rs    (byte_rs),
        .byte_val   (byte_val),
        .disp_on    (disp_on),
        .mode4      (mode4),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (byte_valid) begin
            pulses   <= pulses + 1;
            last_rs  <= byte_rs;
            last_val <= byte_val;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rs, input logic [7:0] b, input logic chk,
                       input logic [4:0] addr, input logic [7:0] exp, input logic disp);
        vec_t v;
        v.rs = rs; v.b = b; v.chk = chk; v.addr = addr; v.exp = exp; v.disp = disp;
        vecs.push_back(v);
    endtask

    task automatic nib(input logic rs, input logic rw, input logic [3:0] d,
                       input int hi, input int idle);
        @(negedge clk);
        control = {1'b1, rs, rw};
        dataout = d;
        repeat (hi) @(negedge clk);
        control = {1'b0, rs, rw};
        repeat (idle) @(negedge clk);
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b, input int idle);
        nib(rs, 1'b0, b[7:4], 2, 3);
        nib(rs, 1'b0, b[3:0], 2, idle);
    endtask

    task automatic read_ram(input logic [4:0] a, output logic [7:0] d);
        @(negedge clk);
        RADD = a;
        @(negedge clk);
        d = RDATA;
    endtask

    task automatic check_all_blank(input string name);
        logic [7:0] d;
        for (int a = 0; a < 32; a++) begin
            read_ram(5'(a), d);
            check($sformatf("%s[%0d]", name, a), d, 8'h20);
        end
    endtask

    initial begin
        logic [7:0] d;
        int p0;

        add(0, 8'h80, 0, 5'd0,  8'h00, 1);
        add(1, 8'h48, 1, 5'd0,  8'h48, 1);
        add(1, 8'h69, 1, 5'd1,  8'h69, 1);
        add(0, 8'hC0, 0, 5'd0,  8'h00, 1);
        for (int k = 0; k < 16; k++) begin
            add(1, 8'(8'h41 + k), 1, 5'(16 + k), 8'(8'h41 + k), 1);
        end
        add(1, 8'h51, 1, 5'd0,  8'h51, 1);
        add(0, 8'h04, 0, 5'd0,  8'h00, 1);
        add(0, 8'h85, 0, 5'd0,  8'h00, 1);
        add(1, 8'h5A, 1, 5'd5,  8'h5A, 1);
        add(1, 8'h5B, 1, 5'd4,  8'h5B, 1);
        add(0, 8'h80, 0, 5'd0,  8'h00, 1);
        add(1, 8'h61, 1, 5'd0,  8'h61, 1);
        add(1, 8'h62, 1, 5'd31, 8'h62, 1);
        add(0, 8'h06, 0, 5'd0,  8'h00, 1);
        add(0, 8'h08, 0, 5'd0,  8'h00, 0);
        add(0, 8'h0C, 0, 5'd0,  8'h00, 1);
        add(0, 8'h30, 0, 5'd0,  8'h00, 1);
        add(0, 8'h01, 1, 5'd0,  8'h20, 1);
        add(0, 8'h02, 1, 5'd31, 8'h20, 1);
        add(1, 8'h77, 1, 5'd0,  8'h77, 1);

        rst = 1'b1;
        control = 3'b000;
        dataout = 4'h0;
        RADD = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", RDATA, 8'h00);
        check("rst_byte_valid", byte_valid, 1'b0);
        check("rst_byte_rs", byte_rs, 1'b0);
        check("rst_byte_val", byte_val, 8'h00);
        check("rst_disp_on", disp_on, 1'b0);
        check("rst_mode4", mode4, 1'b0);
        check("rst_err", err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        nib(0, 0, 4'h3, 2, 3);
        nib(0, 0, 4'h3, 2, 3);
        nib(0, 0, 4'h3, 2, 3);
        check("init_mode4_early", mode4, 1'b0);
        nib(0, 0, 4'h2, 2, 3);
        check("init_mode4", mode4, 1'b1);
        send_byte(0, 8'h28, IDLE_BYTE);
        send_byte(0, 8'h0C, IDLE_BYTE);
        send_byte(0, 8'h06, IDLE_BYTE);
        send_byte(0, 8'h01, CLR_WAIT);
        check("init_disp_on", disp_on, 1'b1);
        check("init_err", err, 1'b0);
        check("init_pulses", pulses, 4);
        check_all_blank("init_ram");

        foreach (vecs[i]) begin
            p0 = pulses;
            send_byte(vecs[i].rs, vecs[i].b,
                      (!vecs[i].rs && vecs[i].b == 8'h01) ? CLR_WAIT : IDLE_BYTE);
            check($sformatf("vec%0d_pulse", i), pulses - p0, 1);
            check($sformatf("vec%0d_val", i), last_val, vecs[i].b);
            check($sformatf("vec%0d_rs", i), last_rs, vecs[i].rs);
            check($sformatf("vec%0d_disp", i), disp_on, vecs[i].disp);
            if (vecs[i].chk) begin
                read_ram(vecs[i].addr, d);
                check($sformatf("vec%0d_ram", i), d, vecs[i].exp);
            end
        end
        check("table_err", err, 1'b0);

`ifdef LCD_BUS_RX_BUSY_EN
        p0 = pulses;
        send_byte(1, 8'h31, 100);
        send_byte(1, 8'h32, 3);
        repeat (200) @(negedge clk);
        check("busy_pulses", pulses - p0, 1);
        check("busy_err", err, 1'b1);
        read_ram(5'd2, d);
        check("busy_drop_ram", d, 8'h20);
`endif

        p0 = pulses;
        read_ram(GA, d);
        check("glitch_pre_ram", d, 8'h20);
        nib(1, 0, 4'hF, 1, 5);
        nib(1, 1, 4'hE, 2, 5);
        check("glitch_err", err, 1'b1);
        check("glitch_pulses", pulses - p0, 0);
        read_ram(GA, d);
        check("glitch_ram_kept", d, 8'h20);
        send_byte(1, 8'h55, IDLE_BYTE);
        check("glitch_next_val", last_val, 8'h55);
        read_ram(GA, d);
        check("glitch_cursor", d, 8'h55);
        read_ram(GA - 5'd1, d);
        check("glitch_prev_ram", d, GA_PREV);

        p0 = pulses;
        nib(1, 0, 4'h4, 2, 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_err", err, 1'b0);
        check("midrst_mode4", mode4, 1'b0);
        check("midrst_disp", disp_on, 1'b0);
        repeat (40) @(negedge clk);
        check("midrst_pulses", pulses - p0, 0);
        check_all_blank("midrst_ram");
        nib(0, 0, 4'h3, 2, 3);
        nib(0, 0, 4'h2, 2, 3);
        check("midrst_reinit_mode4", mode4, 1'b1);
        check("midrst_reinit_err", err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
